dram_page_ctrl: RTL

Synchronous, parametrised controller for the asynchronous RAS/CAS DRAM array.
- Turns a valid/ready host request stream into RAS_N/CAS_N/MA/WE_N/OE_N strobe sequences with programmable cycle timing.
- Keeps the last row open, so same-row accesses use page mode and skip row activation.
- Runs periodic CAS-before-RAS refresh on its own.
- Sits between the system bus and the DRAM array. The top level merges DQ_O, DQ_OE and DQ_I into the array's inout data bus.

---
 rtl/dram_page_ctrl.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dram_page_ctrl.sv
// dram_page_ctrl: page-mode RAS/CAS DRAM controller with CAS-before-RAS refresh.
// The last activated row stays open so that same-row accesses skip activation.
//
// state | meaning
// IDLE  | waiting for a request or an owed refresh; a page may be open
// PRE   | RAS high for T_RP, closing the page before a new row or a refresh
// ACT   | RAS low with the row on MA for T_RCD
// COL   | CAS low with the column on MA for T_CAS
// CPRE  | CAS precharge for one cycle; RAS stays low, page stays open
// RCAS  | refresh: CAS low one cycle ahead of RAS
// RRAS  | refresh: RAS and CAS both low for T_RAS
// REND  | refresh: both strobes high for T_RP, then back to IDLE
module dram_page_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ROW_W   = 10,
  parameter int COL_W   = 8,
  parameter int T_RCD   = 2,
  parameter int T_CAS   = 2,
  parameter int T_RP    = 2,
  parameter int T_RAS   = 4,
  parameter int REF_INT = 780,
  localparam int BE_W   = DATA_W / 8,
  localparam int ADDR_W = ROW_W + COL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [BE_W-1:0]   req_be,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ras_n,
  output logic              cas_n,
  output logic              oe_n,
  output logic [BE_W-1:0]   we_n,
  output logic [ROW_W-1:0]  ma,
  output logic [DATA_W-1:0] dq_o,
  output logic              dq_oe,
  input  logic [DATA_W-1:0] dq_i
);

  localparam int TW    = 8;
  localparam int REF_W = (REF_INT > 2) ? $clog2(REF_INT) : 1;
  localparam logic [REF_W-1:0] REF_RELOAD = REF_W'(REF_INT - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_ACT, ST_COL, ST_CPRE, ST_RCAS, ST_RRAS, ST_REND
  } state_t;

  state_t            state;
  logic [TW-1:0]     tmr;
  logic [REF_W-1:0]  ref_cnt;
  logic              ref_tc;
  logic              ref_pend;
  logic              ref_busy;
  logic              row_open;
  logic [ROW_W-1:0]  open_row;
  logic [ROW_W-1:0]  lat_row;
  logic [COL_W-1:0]  lat_col;
  logic              lat_we;
  logic [BE_W-1:0]   lat_be;
  logic [DATA_W-1:0] lat_wdata;
  logic [ROW_W-1:0]  req_row;
  logic [COL_W-1:0]  req_col;
  logic              accept;
  logic              tmr_tc;
  logic              col_we;
  logic [BE_W-1:0]   col_be;
  logic [DATA_W-1:0] col_wdata;
  logic [COL_W-1:0]  col_addr;

  assign req_row   = req_addr[ADDR_W-1:COL_W];
  assign req_col   = req_addr[COL_W-1:0];
  assign req_ready = (state == ST_IDLE) && !ref_pend;
  assign accept    = req_valid && req_ready;
  assign tmr_tc    = (tmr == '0);
  assign ref_tc    = (ref_cnt == '0);

  // Column phase starts either straight from IDLE on a page hit (live request)
  // or from ACT (latched request); pick the matching source.
  always_comb begin
    if (state == ST_IDLE) begin
      col_we    = req_we;
      col_be    = req_be;
      col_wdata = req_wdata;
      col_addr  = req_col;
    end else begin
      col_we    = lat_we;
      col_be    = lat_be;
      col_wdata = lat_wdata;
      col_addr  = lat_col;
    end
  end

  // Free-running refresh interval down-counter; terminal count flags a refresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= REF_RELOAD;
    end else if (ref_tc) begin
      ref_cnt <= REF_RELOAD;
    end else begin
      ref_cnt <= ref_cnt - REF_W'(1);
    end
  end

  // Main sequencer: strobe generation, page tracking and refresh bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      ref_pend  <= 1'b0;
      ref_busy  <= 1'b0;
      row_open  <= 1'b0;
      open_row  <= '0;
      lat_row   <= '0;
      lat_col   <= '0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_wdata <= '0;
      ras_n     <= 1'b1;
      cas_n     <= 1'b1;
      oe_n      <= 1'b1;
      we_n      <= '1;
      ma        <= '0;
      dq_o      <= '0;
      dq_oe     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      // A second expiry while one refresh is already owed is simply absorbed.
      if (ref_tc) ref_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (ref_pend) begin
            ref_busy <= 1'b1;
            if (row_open) begin
              state    <= ST_PRE;
              ras_n    <= 1'b1;
              row_open <= 1'b0;
              tmr      <= TW'(T_RP - 1);
            end else begin
              state <= ST_RCAS;
              cas_n <= 1'b0;
            end
          end else if (accept) begin
            lat_row   <= req_row;
            lat_col   <= req_col;
            lat_we    <= req_we;
            lat_be    <= req_be;
            lat_wdata <= req_wdata;
            if (row_open && (req_row == open_row)) begin
              state <= ST_COL;
              cas_n <= 1'b0;
              ma    <= ROW_W'(col_addr);
              tmr   <= TW'(T_CAS - 1);
              if (col_we) begin
                we_n  <= ~col_be;
                dq_oe <= 1'b1;
                dq_o  <= col_wdata;
              end else begin
                oe_n <= 1'b0;
              end
            end else if (row_open) begin
              state    <= ST_PRE;
              ras_n    <= 1'b1;
              row_open <= 1'b0;
              tmr      <= TW'(T_RP - 1);
            end else begin
              state <= ST_ACT;
              ras_n <= 1'b0;
              ma    <= req_row;
              tmr   <= TW'(T_RCD - 1);
            end
          end
        end
        ST_PRE: begin
          if (!tmr_tc) begin
            tmr <= tmr - TW'(1);
          end else if (ref_busy) begin
            state <= ST_RCAS;
            cas_n <= 1'b0;
          end else begin
            state <= ST_ACT;
            ras_n <= 1'b0;
            ma    <= lat_row;
            tmr   <= TW'(T_RCD - 1);
          end
        end
        ST_ACT: begin
          if (!tmr_tc) begin
            tmr <= tmr - TW'(1);
          end else begin
            state    <= ST_COL;
            open_row <= lat_row;
            row_open <= 1'b1;
            cas_n    <= 1'b0;
            ma       <= ROW_W'(col_addr);
            tmr      <= TW'(T_CAS - 1);
            if (col_we) begin
              we_n  <= ~col_be;
              dq_oe <= 1'b1;
              dq_o  <= col_wdata;
            end else begin
              oe_n <= 1'b0;
            end
          end
        end
        ST_COL: begin
          if (!tmr_tc) begin
            tmr <= tmr - TW'(1);
          end else begin
            state <= ST_CPRE;
            cas_n <= 1'b1;
            oe_n  <= 1'b1;
            we_n  <= '1;
            dq_oe <= 1'b0;
            if (!lat_we) begin
              rsp_rdata <= dq_i;
              rsp_valid <= 1'b1;
            end
          end
        end
        ST_CPRE: begin
          state <= ST_IDLE;
        end
        ST_RCAS: begin
          state <= ST_RRAS;
          ras_n <= 1'b0;
          tmr   <= TW'(T_RAS - 1);
        end
        ST_RRAS: begin
          if (!tmr_tc) begin
            tmr <= tmr - TW'(1);
          end else begin
            state <= ST_REND;
            ras_n <= 1'b1;
            cas_n <= 1'b1;
            tmr   <= TW'(T_RP - 1);
          end
        end
        ST_REND: begin
          if (!tmr_tc) begin
            tmr <= tmr - TW'(1);
          end else begin
            state    <= ST_IDLE;
            ref_pend <= 1'b0;
            ref_busy <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
